// File: rtl/wash_timer.sv
// Wash/spin phase timer: down-counts motor-on cycles, raises registered timeout levels; no backpressure.
// Status ports (remaining, phase) are live only with WASH_TIMER_STATUS_EN defined, else tied to 0.
module wash_timer #(
    parameter int WASH_CYCLES = 16,
    parameter int SPIN_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             drain_valve_on,
    input  logic             done,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       phase
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WASH_RUN  = 3'd1;
    localparam logic [2:0] S_WASH_DONE = 3'd2;
    localparam logic [2:0] S_SPIN_RUN  = 3'd3;
    localparam logic [2:0] S_SPIN_DONE = 3'd4;

    localparam logic [CNT_W-1:0] WASH_LOAD = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(SPIN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cyc_to_q, cyc_to_d;
    logic             spin_to_q, spin_to_d;
    logic             water_prev_q;

    logic start_ok, rinse_edge, spin_ok;

    assign start_ok   = motor_on && (soap_wash || water_wash) && !drain_valve_on;
    assign rinse_edge = water_wash && !water_prev_q;
    assign spin_ok    = motor_on && drain_valve_on && !soap_wash && !water_wash;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cyc_to_d  = cyc_to_q;
        spin_to_d = spin_to_q;
        if (done) begin
            state_d   = S_IDLE;
            count_d   = '0;
            cyc_to_d  = 1'b0;
            spin_to_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d = S_WASH_RUN;
                        count_d = WASH_LOAD;
                    end
                end
                S_WASH_RUN: begin
                    if (motor_on) begin
                        if (count_q == '0) begin
                            state_d  = S_WASH_DONE;
                            cyc_to_d = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
                S_WASH_DONE: begin
                    // Rinse restart outranks the move to spin.
                    if (rinse_edge) begin
                        state_d  = S_WASH_RUN;
                        count_d  = WASH_LOAD;
                        cyc_to_d = 1'b0;
                    end else if (spin_ok) begin
                        state_d  = S_SPIN_RUN;
                        count_d  = SPIN_LOAD;
                        cyc_to_d = 1'b0;
                    end
                end
                S_SPIN_RUN: begin
                    if (motor_on) begin
                        if (count_q == '0) begin
                            state_d   = S_SPIN_DONE;
                            spin_to_d = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
                S_SPIN_DONE: ;
                default: begin
                    state_d   = S_IDLE;
                    count_d   = '0;
                    cyc_to_d  = 1'b0;
                    spin_to_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            cyc_to_q     <= 1'b0;
            spin_to_q    <= 1'b0;
            water_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cyc_to_q     <= cyc_to_d;
            spin_to_q    <= spin_to_d;
            water_prev_q <= water_wash;
        end
    end

    assign cycle_timeout = cyc_to_q;
    assign spin_timeout  = spin_to_q;

`ifdef WASH_TIMER_STATUS_EN
    logic [1:0] phase_code;
    always_comb begin
        case (state_q)
            S_WASH_RUN:  phase_code = 2'd1;
            S_SPIN_RUN:  phase_code = 2'd2;
            S_WASH_DONE,
            S_SPIN_DONE: phase_code = 2'd3;
            default:     phase_code = 2'd0;
        endcase
    end
    assign remaining = count_q;
    assign phase     = phase_code;
`else
    assign remaining = '0;
    assign phase     = 2'd0;
`endif

endmodule

// File: doc/wash_timer.md
WASH_TIMER -- requirements
Module: wash_timer

Interface
REQ-001 The module SHALL have parameter WASH_CYCLES, default 16, giving the wash-phase duration in motor-on clock cycles (legal range 1..2^CNT_W).
REQ-002 The module SHALL have parameter SPIN_CYCLES, default 8, giving the spin-phase duration in motor-on clock cycles (legal range 1..2^CNT_W).
REQ-003 The module SHALL have parameter CNT_W, default 8, giving the down-counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 motor_on  input  1  drum motor running, from the washer controller.
REQ-007 soap_wash  input  1  soap-wash phase active.
REQ-008 water_wash  input  1  rinse (water-wash) phase active.
REQ-009 drain_valve_on  input  1  drain valve open.
REQ-010 done  input  1  washer cycle complete; aborts timing.
REQ-011 cycle_timeout  output  1  wash phase elapsed; level, registered.
REQ-012 spin_timeout  output  1  spin phase elapsed; level, registered.
REQ-013 remaining  output  CNT_W  current down-counter value.
REQ-014 phase  output  2  timer state code: 0 IDLE, 1 WASH, 2 SPIN, 3 EXPIRED (WASH_DONE or SPIN_DONE).

Function
REQ-015 The FSM SHALL have states IDLE, WASH_RUN, WASH_DONE, SPIN_RUN and SPIN_DONE.
REQ-016 IDLE -> WASH_RUN when motor_on=1, (soap_wash or water_wash)=1 and drain_valve_on=0; count loads WASH_CYCLES-1 on that edge.
REQ-017 In WASH_RUN and SPIN_RUN, count SHALL decrement by 1 on each edge with motor_on=1 and hold when motor_on=0 (pause).
REQ-018 In WASH_RUN, an edge with count=0 and motor_on=1 SHALL move to WASH_DONE and set cycle_timeout=1; with motor_on held high, cycle_timeout rises exactly WASH_CYCLES edges after the entry edge.
REQ-019 In WASH_DONE, cycle_timeout SHALL stay 1; a rising edge of water_wash (1 now, 0 on the previous edge) SHALL reload WASH_CYCLES-1, clear cycle_timeout and return to WASH_RUN (rinse after soap).
REQ-020 In WASH_DONE, motor_on=1, drain_valve_on=1, soap_wash=0 and water_wash=0 SHALL load SPIN_CYCLES-1, clear cycle_timeout and enter SPIN_RUN; if both REQ-019 and REQ-020 conditions hold, REQ-019 wins.
REQ-021 In SPIN_RUN, an edge with count=0 and motor_on=1 SHALL enter SPIN_DONE and set spin_timeout=1; spin_timeout rises SPIN_CYCLES edges after entry with motor_on held high.
REQ-022 In SPIN_DONE, spin_timeout SHALL stay 1 until done=1.
REQ-023 done=1 in any state SHALL force IDLE on the next edge, with count=0 and both timeouts 0; done takes priority over all other transitions.
REQ-024 count SHALL never wrap below 0; cycle_timeout and spin_timeout SHALL never be 1 simultaneously.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE, count=0, cycle_timeout=0, spin_timeout=0, phase=0, and clear the water_wash edge register, regardless of state (including mid-count).
REQ-026 reset SHALL take priority over done and all other inputs.

Configuration
REQ-027 With macro WASH_TIMER_STATUS_EN defined, remaining SHALL equal count and phase SHALL equal the state code of REQ-014; without it, both ports SHALL remain present and be driven to constant 0, with timeout behaviour unchanged.

Verification
REQ-028 WASH_CYCLES=4, reset released, motor_on=1, soap_wash=1 from edge 1 -> cycle_timeout=1 from edge 5; remaining 3,2,1,0 at edges 1-4 (STATUS_EN).
REQ-029 As REQ-028 with motor_on=0 for 2 edges mid-count -> count holds; cycle_timeout delayed to edge 7.
REQ-030 In WASH_DONE, soap_wash 1->0 and water_wash 0->1 -> cycle_timeout clears next edge; reasserts 4 edges later.
REQ-031 In WASH_DONE, drain_valve_on=1, motor_on=1, soap_wash=water_wash=0, SPIN_CYCLES=2 -> spin_timeout=1 two edges after SPIN_RUN entry; held until done=1, then 0 with phase=0 next edge.
REQ-032 reset=0 during SPIN_RUN at remaining=1 -> next edge: phase=0, remaining=0, both timeouts 0.
REQ-033 Build without WASH_TIMER_STATUS_EN, rerun REQ-028 -> identical timeouts; remaining and phase constant 0.
